// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line and receive-result bundle for uart_rx
// Signals:
//   rx          serial line into the receiver (idles high)
//   data_out    last received byte
//   rx_valid    one-cycle pulse per completed frame
//   parity_err  even-parity check result of the last frame
//   frame_err   stop-bit check result of the last frame
//   busy        receiver is not idle
// Modports: master drives the line and observes results; slave is the receiver.
interface uart_rx_if;
    logic       rx;
    logic [7:0] data_out;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;
    modport master (output rx, input data_out, rx_valid, parity_err, frame_err, busy);
    modport slave  (input rx, output data_out, rx_valid, parity_err, frame_err, busy);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8E1 UART receiver with 2-flop synchronizer, parity/stop checks and break handling
// Ports:
//   clk    single clock, all logic on posedge
//   reset  synchronous active-high reset
//   bus    uart_rx_if.slave: rx in; data_out, rx_valid, parity_err, frame_err, busy out
// Parameter CLKS_PER_BIT (1..255) sets the bit period in clocks.
module uart_rx #(
    parameter int CLKS_PER_BIT = 1
) (
    input logic     clk,
    input logic     reset,
    uart_rx_if.slave bus
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;
    localparam logic [7:0] BIT_LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic [7:0] HALF     = 8'((CLKS_PER_BIT - 1) / 2);
    state_t     r_state, w_next;
    logic [1:0] r_sync;
    logic [7:0] r_baud, r_shift, r_data;
    logic [2:0] r_idx;
    logic       r_par, r_valid, r_perr, r_ferr;
    logic       w_rx_s, w_in_frame, w_sample;
    assign w_rx_s     = r_sync[1];
    assign w_in_frame = r_state inside {START, DATA, PARITY, STOP};
    assign w_sample   = w_in_frame && (r_baud == 8'd0);
    assign bus.data_out   = r_data;
    assign bus.rx_valid   = r_valid;
    assign bus.parity_err = r_perr;
    assign bus.frame_err  = r_ferr;
    assign bus.busy       = r_state != IDLE;
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_rx_s ? IDLE : ((HALF == 8'd0) ? DATA : START);
            START:   w_next = w_sample ? (w_rx_s ? IDLE : DATA) : START;
            DATA:    w_next = (w_sample && r_idx == 3'd7) ? PARITY : DATA;
            PARITY:  w_next = w_sample ? STOP : PARITY;
            STOP:    w_next = w_sample ? (w_rx_s ? IDLE : BRK) : STOP;
            BRK:     w_next = w_rx_s ? IDLE : BRK;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync  <= 2'b11;
            r_baud  <= 8'd0;
            r_idx   <= 3'd0;
            r_shift <= 8'd0;
            r_par   <= 1'b0;
            r_data  <= 8'd0;
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], bus.rx};
            r_valid <= 1'b0;
            if (r_state == IDLE && !w_rx_s) begin
                // with no half-bit delay the start edge itself is the centre of the start bit
                r_baud <= (HALF == 8'd0) ? BIT_LAST : HALF - 8'd1;
                r_idx  <= 3'd0;
            end else if (w_in_frame) begin
                if (r_baud != 8'd0) begin
                    r_baud <= r_baud - 8'd1;
                end else begin
                    r_baud <= BIT_LAST;
                    case (r_state)
                        START:  r_idx <= 3'd0;
                        DATA: begin
                            r_shift <= {w_rx_s, r_shift[7:1]};
                            r_idx   <= r_idx + 3'd1;
                        end
                        PARITY: r_par <= w_rx_s;
                        STOP: begin
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
                            r_perr  <= r_par ^ (^r_shift);
                            r_ferr  <= !w_rx_s;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx at CLKS_PER_BIT=1 and 16
module tb_uart_rx;
    logic       clk;
    logic       reset;
    int         cyc;
    int         vecs;
    int         errs;
    int         q_cyc[$];
    logic [7:0] q_dat[$];
    logic       q_pe[$];
    logic       q_fe[$];
    int         n16;
    int         last16;

    uart_rx_if if1 ();
    uart_rx_if if16 ();

    uart_rx #(.CLKS_PER_BIT(1))  u1  (.clk(clk), .reset(reset), .bus(if1.slave));
    uart_rx #(.CLKS_PER_BIT(16)) u16 (.clk(clk), .reset(reset), .bus(if16.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (if1.rx_valid) begin
            q_cyc.push_back(cyc);
            q_dat.push_back(if1.data_out);
            q_pe.push_back(if1.parity_err);
            q_fe.push_back(if1.frame_err);
        end
        if (if16.rx_valid) begin
            n16    = n16 + 1;
            last16 = cyc;
        end
    end

    task automatic drive(input bit fast, input logic b, input int n);
        if (fast) if1.rx = b;
        else      if16.rx = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input bit fast, input logic [7:0] d, input logic p, input logic s, output int t0);
        logic [10:0] f;
        f  = {s, p, d, 1'b0};
        t0 = cyc;
        for (int i = 0; i < 11; i++) drive(fast, f[i], fast ? 1 : 16);
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        if1.rx  = 1'b1;
        if16.rx = 1'b1;
        repeat (3) @(negedge clk);
        vecs++; if ({if1.data_out, if1.rx_valid, if1.parity_err, if1.frame_err, if1.busy} !== 12'h000) begin errs++; $display("FAIL reset_outs1 got %h exp 000", {if1.data_out, if1.rx_valid, if1.parity_err, if1.frame_err, if1.busy}); end
        vecs++; if ({if16.data_out, if16.rx_valid, if16.parity_err, if16.frame_err, if16.busy} !== 12'h000) begin errs++; $display("FAIL reset_outs16 got %h exp 000", {if16.data_out, if16.rx_valid, if16.parity_err, if16.frame_err, if16.busy}); end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        vecs++; if ({if1.busy, if16.busy} !== 2'b00) begin errs++; $display("FAIL idle_busy got %b exp 00", {if1.busy, if16.busy}); end
    endtask

    task automatic test_a5();
        int base, t0;
        base = q_cyc.size();
        frame(1, 8'hA5, 1'b0, 1'b1, t0);
        drive(1, 1'b1, 5);
        vecs++; if (q_cyc.size() - base !== 1) begin errs++; $display("FAIL a5_count got %0d exp 1", q_cyc.size() - base); end
        if (q_cyc.size() > base) begin
            vecs++; if (q_cyc[base] !== t0 + 13) begin errs++; $display("FAIL a5_latency got %0d exp %0d", q_cyc[base], t0 + 13); end
            vecs++; if (q_dat[base] !== 8'hA5) begin errs++; $display("FAIL a5_data got %h exp a5", q_dat[base]); end
            vecs++; if ({q_pe[base], q_fe[base]} !== 2'b00) begin errs++; $display("FAIL a5_flags got %b exp 00", {q_pe[base], q_fe[base]}); end
        end
        vecs++; if (if1.busy !== 1'b0) begin errs++; $display("FAIL a5_busy got %b exp 0", if1.busy); end
    endtask

    task automatic test_parity();
        int base, t0;
        base = q_cyc.size();
        frame(1, 8'h07, 1'b0, 1'b1, t0);
        drive(1, 1'b1, 5);
        vecs++; if (q_cyc.size() - base !== 1) begin errs++; $display("FAIL par_count got %0d exp 1", q_cyc.size() - base); end
        vecs++; if (if1.data_out !== 8'h07) begin errs++; $display("FAIL par_data got %h exp 07", if1.data_out); end
        vecs++; if ({if1.parity_err, if1.frame_err} !== 2'b10) begin errs++; $display("FAIL par_flags got %b exp 10", {if1.parity_err, if1.frame_err}); end
    endtask

    task automatic test_reset_mid();
        int base, t0;
        logic [10:0] f;
        f    = {1'b1, 1'b0, 8'hC3, 1'b0};
        base = q_cyc.size();
        for (int i = 0; i < 6; i++) drive(1, f[i], 1);
        reset = 1'b1;
        drive(1, 1'b1, 2);
        reset = 1'b0;
        drive(1, 1'b1, 20);
        vecs++; if (q_cyc.size() !== base) begin errs++; $display("FAIL rmid_novalid got %0d exp %0d", q_cyc.size(), base); end
        vecs++; if ({if1.data_out, if1.rx_valid, if1.parity_err, if1.frame_err, if1.busy} !== 12'h000) begin errs++; $display("FAIL rmid_outs got %h exp 000", {if1.data_out, if1.rx_valid, if1.parity_err, if1.frame_err, if1.busy}); end
        frame(1, 8'h5A, 1'b0, 1'b1, t0);
        drive(1, 1'b1, 5);
        vecs++; if (q_cyc.size() - base !== 1) begin errs++; $display("FAIL rmid_count got %0d exp 1", q_cyc.size() - base); end
        vecs++; if ({if1.data_out, if1.parity_err, if1.frame_err} !== {8'h5A, 2'b00}) begin errs++; $display("FAIL rmid_5a got %h exp 168", {if1.data_out, if1.parity_err, if1.frame_err}); end
    endtask

    task automatic test_back_to_back();
        int base, t0, t1;
        base = q_cyc.size();
        frame(1, 8'hFF, 1'b0, 1'b1, t0);
        drive(1, 1'b1, 1);
        frame(1, 8'h00, 1'b0, 1'b1, t1);
        drive(1, 1'b1, 5);
        vecs++; if (q_cyc.size() - base !== 2) begin errs++; $display("FAIL b2b_count got %0d exp 2", q_cyc.size() - base); end
        if (q_cyc.size() >= base + 2) begin
            vecs++; if (q_cyc[base] !== t0 + 13) begin errs++; $display("FAIL b2b_first_cyc got %0d exp %0d", q_cyc[base], t0 + 13); end
            vecs++; if (q_cyc[base + 1] - q_cyc[base] !== 12) begin errs++; $display("FAIL b2b_gap got %0d exp 12", q_cyc[base + 1] - q_cyc[base]); end
            vecs++; if (q_dat[base] !== 8'hFF) begin errs++; $display("FAIL b2b_data0 got %h exp ff", q_dat[base]); end
            vecs++; if (q_dat[base + 1] !== 8'h00) begin errs++; $display("FAIL b2b_data1 got %h exp 00", q_dat[base + 1]); end
            vecs++; if ({q_pe[base], q_fe[base], q_pe[base + 1], q_fe[base + 1]} !== 4'b0000) begin errs++; $display("FAIL b2b_flags got %b exp 0000", {q_pe[base], q_fe[base], q_pe[base + 1], q_fe[base + 1]}); end
        end
    endtask

    task automatic test_break();
        int n0, t0;
        n0 = n16;
        frame(0, 8'h3C, 1'b0, 1'b0, t0);
        drive(0, 1'b0, 14);
        vecs++; if (n16 - n0 !== 1) begin errs++; $display("FAIL brk_count got %0d exp 1", n16 - n0); end
        vecs++; if (last16 !== t0 + 170) begin errs++; $display("FAIL brk_latency got %0d exp %0d", last16, t0 + 170); end
        vecs++; if ({if16.data_out, if16.parity_err, if16.frame_err} !== {8'h3C, 2'b01}) begin errs++; $display("FAIL brk_result got %h exp 0f1", {if16.data_out, if16.parity_err, if16.frame_err}); end
        vecs++; if (if16.busy !== 1'b1) begin errs++; $display("FAIL brk_held got %b exp 1", if16.busy); end
        drive(0, 1'b0, 10);
        vecs++; if (if16.busy !== 1'b1) begin errs++; $display("FAIL brk_held_end got %b exp 1", if16.busy); end
        drive(0, 1'b1, 5);
        vecs++; if (if16.busy !== 1'b0) begin errs++; $display("FAIL brk_release got %b exp 0", if16.busy); end
        drive(0, 1'b1, 40);
        vecs++; if (n16 - n0 !== 1) begin errs++; $display("FAIL brk_no_second got %0d exp 1", n16 - n0); end
    endtask

    task automatic test_glitch();
        int n0;
        n0 = n16;
        drive(0, 1'b0, 4);
        vecs++; if (if16.busy !== 1'b1) begin errs++; $display("FAIL glitch_start got %b exp 1", if16.busy); end
        drive(0, 1'b1, 6);
        vecs++; if (if16.busy !== 1'b0) begin errs++; $display("FAIL glitch_drop got %b exp 0", if16.busy); end
        drive(0, 1'b1, 200);
        vecs++; if (n16 !== n0) begin errs++; $display("FAIL glitch_novalid got %0d exp %0d", n16, n0); end
        vecs++; if ({if16.data_out, if16.busy} !== {8'h3C, 1'b0}) begin errs++; $display("FAIL glitch_hold got %h exp 078", {if16.data_out, if16.busy}); end
    endtask

    initial begin
        vecs    = 0;
        errs    = 0;
        n16     = 0;
        last16  = 0;
        reset   = 1'b1;
        if1.rx  = 1'b1;
        if16.rx = 1'b1;
        @(negedge clk);
        test_reset();
        test_a5();
        test_parity();
        test_reset_mid();
        test_back_to_back();
        test_break();
        test_glitch();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
